// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. It scans the digits, applies PWM brightness and optional
// leading-zero suppression. All inputs are captured into shadow registers once
// per frame, so a value that changes mid-scan never produces a torn display.
module seg7_scan_driver #(
    parameter int PHASE_CYCLES = 6250
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        lz_sup,
    input  logic [3:0]  bright,
    input  logic        en,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int              PS_W    = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PHASE_CYCLES - 1);

    // Scan counters
    logic [PS_W-1:0] prescale_reg, prescale_next;
    logic [3:0]      phase_reg, phase_next;
    logic [1:0]      idx_reg, idx_next;

    // Shadow copies of the inputs, reloaded only at the end of each frame
    logic [15:0] value_sh_reg, value_sh_next;
    logic [3:0]  dp_sh_reg, dp_sh_next;
    logic [3:0]  blank_sh_reg, blank_sh_next;
    logic        lz_sh_reg, lz_sh_next;
    logic [3:0]  bright_sh_reg, bright_sh_next;
    logic        en_sh_reg, en_sh_next;

    // Registered outputs
    logic [6:0] seg_reg, seg_next;
    logic       dp_n_reg, dp_n_next;
    logic [3:0] an_reg, an_next;
    logic       frame_tick_reg, frame_tick_next;

    logic       snap;
    logic [3:0] nib_zero;
    logic [3:0] sup_mask;
    logic [3:0] an_sel;
    logic [3:0] digit_next;
    logic       lit_next;
    logic       suppressed_next;

    // Active-low glyphs for the hex digits 0..F, segment order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0011000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Advance prescale -> phase -> idx; the last cycle of a frame triggers the snapshot
    always_comb begin
        prescale_next  = prescale_reg + PS_W'(1);
        phase_next     = phase_reg;
        idx_next       = idx_reg;
        snap           = 1'b0;
        value_sh_next  = value_sh_reg;
        dp_sh_next     = dp_sh_reg;
        blank_sh_next  = blank_sh_reg;
        lz_sh_next     = lz_sh_reg;
        bright_sh_next = bright_sh_reg;
        en_sh_next     = en_sh_reg;
        if (prescale_reg == PS_LAST) begin
            prescale_next = '0;
            phase_next    = phase_reg + 4'd1;
            if (phase_reg == 4'd15) begin
                idx_next = idx_reg + 2'd1;
                if (idx_reg == 2'd3) begin
                    snap = 1'b1;
                end
            end
        end
        if (snap) begin
            value_sh_next  = value;
            dp_sh_next     = dp;
            blank_sh_next  = blank;
            lz_sh_next     = lz_sup;
            bright_sh_next = bright;
            en_sh_next     = en;
        end
    end

    // Per-digit zero flags and anode decode, all from the post-edge state
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign nib_zero[gi] = (value_sh_next[gi*4 +: 4] == 4'h0);
            assign an_sel[gi]   = (idx_next != 2'(gi));
        end
    endgenerate

    // A digit is blank-suppressed only if it and every digit to its left are zero
    assign sup_mask[3] = nib_zero[3];
    assign sup_mask[2] = nib_zero[3] & nib_zero[2];
    assign sup_mask[1] = nib_zero[3] & nib_zero[2] & nib_zero[1];
    assign sup_mask[0] = 1'b0;

    // Compute the next output values from the post-edge counters and shadow
    always_comb begin
        digit_next      = value_sh_next[{idx_next, 2'b00} +: 4];
        lit_next        = en_sh_next && !blank_sh_next[idx_next] && (phase_next <= bright_sh_next);
        suppressed_next = lz_sh_next && sup_mask[idx_next];
        an_next         = 4'b1111;
        seg_next        = 7'b1111111;
        dp_n_next       = 1'b1;
        frame_tick_next = snap;
        if (lit_next) begin
            an_next   = an_sel;
            dp_n_next = ~dp_sh_next[idx_next];
            if (!suppressed_next) begin
                seg_next = hex_glyph(digit_next);
            end
        end
    end

    // State, shadow and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_reg   <= '0;
            phase_reg      <= 4'd0;
            idx_reg        <= 2'd0;
            value_sh_reg   <= 16'h0000;
            dp_sh_reg      <= 4'b0000;
            blank_sh_reg   <= 4'b0000;
            lz_sh_reg      <= 1'b0;
            bright_sh_reg  <= 4'd15;
            en_sh_reg      <= 1'b0;
            seg_reg        <= 7'b1111111;
            dp_n_reg       <= 1'b1;
            an_reg         <= 4'b1111;
            frame_tick_reg <= 1'b0;
        end else begin
            prescale_reg   <= prescale_next;
            phase_reg      <= phase_next;
            idx_reg        <= idx_next;
            value_sh_reg   <= value_sh_next;
            dp_sh_reg      <= dp_sh_next;
            blank_sh_reg   <= blank_sh_next;
            lz_sh_reg      <= lz_sh_next;
            bright_sh_reg  <= bright_sh_next;
            en_sh_reg      <= en_sh_next;
            seg_reg        <= seg_next;
            dp_n_reg       <= dp_n_next;
            an_reg         <= an_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign seg        = seg_reg;
    assign dp_n       = dp_n_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver with PHASE_CYCLES=4
// (64-cycle digit slot, 256-cycle frame).
module tb_seg7_scan_driver;

    localparam int SLOT = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_sup;
    logic [3:0]  bright;
    logic        en;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] G_DARK = 7'b1111111;
    localparam logic [6:0] G_0    = 7'b1000000;
    localparam logic [6:0] G_1    = 7'b1111001;
    localparam logic [6:0] G_2    = 7'b0100100;
    localparam logic [6:0] G_5    = 7'b0010010;
    localparam logic [6:0] G_A    = 7'b0001000;
    localparam logic [6:0] G_F    = 7'b0001110;

    seg7_scan_driver #(.PHASE_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .lz_sup     (lz_sup),
        .bright     (bright),
        .en         (en),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the next negedge sample where frame_tick is high (bounded)
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Observe one digit slot starting at the current sample; ends at the next slot start
    task automatic measure_slot(input logic [3:0] an_exp, input logic [6:0] seg_exp,
                                output int n_an, output int n_seg, output int n_dark, output int n_dp);
        n_an = 0; n_seg = 0; n_dark = 0; n_dp = 0;
        for (int i = 0; i < SLOT; i++) begin
            if (an === an_exp) n_an++;
            if (an === an_exp && seg === seg_exp) n_seg++;
            if (an === 4'b1111 && seg === G_DARK && dp_n === 1'b1) n_dark++;
            if (dp_n === 1'b0) n_dp++;
            @(negedge clk);
        end
        $display("slot an=%b seg=%b : anode_cycles=%0d glyph_cycles=%0d dark=%0d dp_low=%0d",
                 an_exp, seg_exp, n_an, n_seg, n_dark, n_dp);
    endtask

    task automatic test_reset();
        bit ok;
        int n_dark;
        reset_n = 1'b0;
        value = 16'h12AF; dp = 4'b0000; blank = 4'b0000; lz_sup = 1'b0; bright = 4'd15; en = 1'b1;
        step(3);
        n_cmp++;
        if (an !== 4'b1111 || seg !== G_DARK || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_initial: an=%b seg=%b dp_n=%b ft=%b, expected 1111/1111111/1/0", an, seg, dp_n, frame_tick);
        end
        reset_n = 1'b1;
        wait_tick(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL reset_first_tick: no frame_tick seen, expected one"); end
        step(10);
        n_cmp++;
        if (an !== 4'b1110 || seg !== G_F) begin
            n_bad++;
            $display("FAIL pre_reset_scan: an=%b seg=%b, expected 1110/0001110", an, seg);
        end
        // Assert reset between clock edges; outputs must clear without an edge
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (an !== 4'b1111 || seg !== G_DARK || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: an=%b seg=%b dp_n=%b ft=%b, expected 1111/1111111/1/0", an, seg, dp_n, frame_tick);
        end
        @(negedge clk);
        reset_n = 1'b1;
        n_dark = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            if (an === 4'b1111 && frame_tick === 1'b0) n_dark++;
        end
        n_cmp++;
        if (n_dark !== 255) begin
            n_bad++;
            $display("FAIL reset_dark_frame: dark cycles=%0d, expected 255", n_dark);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_tick !== 1'b1 || an !== 4'b1110) begin
            n_bad++;
            $display("FAIL reset_tick_256: ft=%b an=%b, expected 1/1110", frame_tick, an);
        end
    endtask

    task automatic test_basic_scan();
        bit ok;
        int a, s, d, p;
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{G_F, G_A, G_2, G_1};
        wait_tick(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL basic_tick: no frame_tick seen, expected one"); end
        for (int sl = 0; sl < 4; sl++) begin
            measure_slot(an_tab[sl], seg_tab[sl], a, s, d, p);
            n_cmp++;
            if (s !== SLOT) begin
                n_bad++;
                $display("FAIL basic_slot%0d: glyph cycles=%0d, expected %0d", sl, s, SLOT);
            end
        end
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_tick_period: ft=%b 256 cycles after previous tick, expected 1", frame_tick);
        end
    endtask

    task automatic test_snapshot();
        int a, s, d, p;
        // Now at frame cycle 0 with 12AF snapshotted
        step(100);
        value = 16'h0000;
        step(28);
        measure_slot(4'b1011, G_2, a, s, d, p);
        n_cmp++;
        if (s !== SLOT) begin n_bad++; $display("FAIL snap_hold_idx2: glyph cycles=%0d, expected %0d", s, SLOT); end
        measure_slot(4'b0111, G_1, a, s, d, p);
        n_cmp++;
        if (s !== SLOT) begin n_bad++; $display("FAIL snap_hold_idx3: glyph cycles=%0d, expected %0d", s, SLOT); end
        n_cmp++;
        if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL snap_tick: ft=%b, expected 1", frame_tick); end
        measure_slot(4'b1110, G_0, a, s, d, p);
        n_cmp++;
        if (s !== SLOT) begin n_bad++; $display("FAIL snap_new_idx0: glyph cycles=%0d, expected %0d", s, SLOT); end
    endtask

    task automatic test_leading_zeros();
        bit ok;
        int a, s, d, p;
        logic [3:0] an_tab [4];
        logic [6:0] exp5 [4];
        logic [6:0] exp105 [4];
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp5   = '{G_5, G_DARK, G_DARK, G_DARK};
        exp105 = '{G_5, G_0, G_1, G_DARK};
        value = 16'h0005; lz_sup = 1'b1;
        wait_tick(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL lz_tick: no frame_tick seen, expected one"); end
        for (int sl = 0; sl < 4; sl++) begin
            measure_slot(an_tab[sl], exp5[sl], a, s, d, p);
            n_cmp++;
            if (s !== SLOT) begin n_bad++; $display("FAIL lz_0005_slot%0d: glyph cycles=%0d, expected %0d", sl, s, SLOT); end
        end
        value = 16'h0000;
        wait_tick(ok);
        measure_slot(4'b1110, G_0, a, s, d, p);
        n_cmp++;
        if (s !== SLOT) begin n_bad++; $display("FAIL lz_0000_idx0: glyph cycles=%0d, expected %0d", s, SLOT); end
        value = 16'h0105;
        wait_tick(ok);
        for (int sl = 0; sl < 4; sl++) begin
            measure_slot(an_tab[sl], exp105[sl], a, s, d, p);
            n_cmp++;
            if (s !== SLOT) begin n_bad++; $display("FAIL lz_0105_slot%0d: glyph cycles=%0d, expected %0d", sl, s, SLOT); end
        end
        lz_sup = 1'b0;
        value = 16'h12AF;
    endtask

    task automatic test_brightness();
        bit ok;
        int a, s, d, p;
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{G_F, G_A, G_2, G_1};
        bright = 4'd3;
        wait_tick(ok);
        wait_tick(ok);
        for (int sl = 0; sl < 4; sl++) begin
            measure_slot(an_tab[sl], seg_tab[sl], a, s, d, p);
            n_cmp++;
            if (s !== 16 || d !== 48) begin
                n_bad++;
                $display("FAIL bright3_slot%0d: on=%0d dark=%0d, expected 16/48", sl, s, d);
            end
        end
        bright = 4'd0;
        wait_tick(ok);
        measure_slot(4'b1110, G_F, a, s, d, p);
        n_cmp++;
        if (s !== 4 || d !== 60) begin
            n_bad++;
            $display("FAIL bright0_idx0: on=%0d dark=%0d, expected 4/60", s, d);
        end
        bright = 4'd15;
    endtask

    task automatic test_blank_dp();
        bit ok;
        int a, s, d, p;
        int dark_total;
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        int exp_an [4];
        int exp_dp [4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{G_F, G_A, G_2, G_1};
        exp_an  = '{64, 64, 0, 64};
        exp_dp  = '{64, 0, 0, 0};
        blank = 4'b0100; dp = 4'b0001;
        wait_tick(ok);
        wait_tick(ok);
        for (int sl = 0; sl < 4; sl++) begin
            measure_slot(an_tab[sl], seg_tab[sl], a, s, d, p);
            n_cmp++;
            if (a !== exp_an[sl] || p !== exp_dp[sl]) begin
                n_bad++;
                $display("FAIL blank_dp_slot%0d: anode=%0d dp_low=%0d, expected %0d/%0d", sl, a, p, exp_an[sl], exp_dp[sl]);
            end
        end
        en = 1'b0;
        wait_tick(ok);
        dark_total = 0;
        for (int sl = 0; sl < 4; sl++) begin
            measure_slot(an_tab[sl], seg_tab[sl], a, s, d, p);
            dark_total += d;
        end
        n_cmp++;
        if (dark_total !== 256) begin
            n_bad++;
            $display("FAIL en_off_frame: dark cycles=%0d, expected 256", dark_total);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_snapshot();
        test_leading_zeros();
        test_brightness();
        test_blank_dp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
